hack_cpu: RTL and testbench
===========================

Name: hack_cpu

Overview:
- Single-cycle Hack execution core; the stage wrapped directly around the existing ALU.
- Decodes each 16-bit instruction and drives the ALU control bits (zx, nx, zy, ny, f, no) and operands.
- Holds the A, D and PC registers and produces the data-memory write port and the next instruction address.
- Instruction ROM and data RAM are external and read combinationally.

Parameters:
- RESET_PC, 15'd0, PC value loaded on reset.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- instruction  input  16  instruction at address pc
- inM  input  16  data RAM read value at addressM
- outM  output  16  ALU result, value to write to RAM
- writeM  output  1  RAM write enable for this cycle
- addressM  output  15  current A[14:0]
- pc  output  15  current program counter

Behaviour:
- Decode, when instruction[15]=0 (A-instr):
  - next A = instruction.
  - D and RAM unchanged; writeM=0.
  - PC advances normally.
- Decode, when instruction[15]=1 (C-instr):
  - a = bit12; comp bits 11..6 = zx,nx,zy,ny,f,no.
  - dest bits 5..3 = A,D,M; jump bits 2..0 = lt,eq,gt.
  - bits 14..13 are ignored.
- ALU operands:
  - x = D.
  - y = inM if a=1, else A.
  - f=1 selects 16-bit add with wrap and no carry out; f=0 selects bitwise AND.
  - zr=1 iff out==0; ng = out[15].
- Outputs:
  - outM = ALU out, purely combinational within the cycle.
  - writeM = C-instr & bit3 & ~reset.
  - addressM = A[14:0] before this cycle's update.
- Register writes, on edge with reset=0:
  - A <= ALU out if C-instr & bit5.
  - D <= ALU out if C-instr & bit4.
- Jump condition:
  - jump = C-instr & ((lt & ng) | (eq & zr) | (gt & ~ng & ~zr)).
  - jjj=111 is an unconditional jump; jjj=000 never jumps.
- Next PC: reset ? RESET_PC : jump ? A[14:0] : pc+1.
  - Increment wraps 15'h7FFF -> 15'h0000.
  - The jump target is the old A, even if the same instruction writes A (e.g. AM=D;JMP).
- Simultaneous destinations (A, D, M): every destination receives the same ALU result, computed from pre-edge A and D.
- Latency:
  - One instruction per clock.
  - The RAM write is committed by the external RAM on the same edge that updates A, D and PC.
- Reset:
  - On a reset edge A=0, D=0, pc=RESET_PC.
  - writeM is held 0 whenever reset=1.
  - Reset asserted mid-program discards the in-flight instruction: no register or RAM write.
  - The first instruction after reset deasserts executes from RESET_PC.
- No X propagation: all registers have defined reset values.

Optional Feature:
- Macro: HACK_CPU_HALT_EN.
- With the macro defined:
  - Adds output port halted (1 bit), registered, reset 0.
  - halted is set on the edge where an unconditional-taken jump (jump=1) has target A[14:0]==pc. This is the Hack end-of-program idiom, e.g. @N / 0;JMP at address N.
  - Once set, it stays set until reset. While set: pc frozen, A/D frozen, writeM forced 0.
- Without the macro: no halted port; the self-loop simply re-executes each cycle, with identical state and no side effects.

Test Plan:
- Add and store:
  - Stimulus after reset: @2; D=A; @3; D=D+A; @0; M=D.
  - Required: on the 6th cycle addressM=0, outM=16'd5, writeM=1.
  - D=5 afterwards; pc=6.
- Conditional jump:
  - Stimulus: D=0 (0xEA90 then 0xE310 style encodings); @10; D;JEQ.
  - Required: pc=10 next cycle.
  - Repeat with D=1: pc increments instead.
  - D;JLT with D=16'h8000 jumps; D;JGT with D=16'h8000 does not.
- Multi-destination:
  - Stimulus: A=7, inM=16'h0041, AMD=M+1.
  - Required: addressM=7, outM=16'h0042, writeM=1.
  - Next cycle A=16'h0042 and D=16'h0042.
- AM=D;JMP with A=20, D=100:
  - Required: pc=20 (old A), A=100 afterwards, RAM[20] written 100.
- PC wrap and reset:
  - Force pc=15'h7FFF with a jump; execute a non-jump instruction; required pc=0.
  - Assert reset mid-sequence during M=D: writeM=0, next pc=RESET_PC, A=D=0.
- With HACK_CPU_HALT_EN:
  - Stimulus: program @4 at address 4, then 0;JMP at address 5 targeting 4 (no halt).
  - Then @6 / 0;JMP placed so target==pc.
  - Required: halted=1 the cycle after the self-jump; pc stays constant for 10 cycles; writeM=0.
  - halted clears on reset.

Source files
------------

// File: rtl/hack_cpu.sv
// Single-cycle Hack execution core: decode, ALU, A/D/PC registers and data-memory port.
// Optional macro HACK_CPU_HALT_EN adds a registered 'halted' output for the @N / 0;JMP idiom.

module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_zeroed;
    logic [15:0] x_final;
    logic [15:0] y_zeroed;
    logic [15:0] y_final;
    logic [15:0] f_result;

    // Classic Hack ALU: optional zero/negate on each operand, add or AND, optional negate of result.
    always_comb begin
        x_zeroed = zx ? 16'h0000 : x;
        x_final  = nx ? ~x_zeroed : x_zeroed;
        y_zeroed = zy ? 16'h0000 : y;
        y_final  = ny ? ~y_zeroed : y_zeroed;
        f_result = f ? (x_final + y_final) : (x_final & y_final);
        out      = no ? ~f_result : f_result;
        zr       = (out == 16'h0000);
        ng       = out[15];
    end

endmodule

module hack_cpu #(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
`ifdef HACK_CPU_HALT_EN
    ,
    output logic        halted
`endif
);

    logic [15:0] reg_a;
    logic [15:0] reg_d;
    logic [14:0] reg_pc;

    logic        is_c;
    logic        a_bit;
    logic [5:0]  comp;
    logic [2:0]  dest;
    logic [2:0]  jmp;
    logic        unused_bits;

    logic [15:0] y_operand;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        jump_taken;
    logic [14:0] pc_next;
    logic        frozen;

    always_comb begin
        is_c        = instruction[15];
        a_bit       = instruction[12];
        comp        = instruction[11:6];
        dest        = instruction[5:3];
        jmp         = instruction[2:0];
        unused_bits = ^instruction[14:13];
    end

    assign y_operand = a_bit ? inM : reg_a;

    hack_alu u_alu (
        .x   (reg_d),
        .y   (y_operand),
        .zx  (comp[5]),
        .nx  (comp[4]),
        .zy  (comp[3]),
        .ny  (comp[2]),
        .f   (comp[1]),
        .no  (comp[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // The jump target is always the pre-edge A, even when this instruction also writes A.
    always_comb begin
        jump_taken = is_c & ((jmp[2] & alu_ng) |
                             (jmp[1] & alu_zr) |
                             (jmp[0] & ~alu_ng & ~alu_zr));
        pc_next    = jump_taken ? reg_a[14:0] : (reg_pc + 15'd1);
    end

`ifdef HACK_CPU_HALT_EN
    logic halt_q;

    // Latches on a taken jump back onto itself; only reset releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else if (!halt_q && jump_taken && (reg_a[14:0] == reg_pc)) begin
            halt_q <= 1'b1;
        end
    end

    assign halted = halt_q;
    assign frozen = halt_q;
`else
    assign frozen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a  <= 16'h0000;
            reg_d  <= 16'h0000;
            reg_pc <= RESET_PC;
        end else if (!frozen) begin
            if (!is_c) begin
                reg_a <= instruction;
            end else if (dest[2]) begin
                reg_a <= alu_out;
            end
            if (is_c && dest[1]) begin
                reg_d <= alu_out;
            end
            reg_pc <= pc_next;
        end
    end

    assign outM     = alu_out;
    assign writeM   = is_c & dest[0] & ~reset & ~frozen;
    assign addressM = reg_a[14:0];
    assign pc       = reg_pc;

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: directed Hack programs plus random instructions against
// a mnemonic-level reference model. Define HACK_CPU_HALT_EN to also exercise the halt feature.

module tb_hack_cpu;

    localparam logic [14:0] RESET_PC = 15'd0;

    localparam logic [15:0] D_EQ_A    = 16'hEC10;
    localparam logic [15:0] D_EQ_DPA  = 16'hE090;
    localparam logic [15:0] M_EQ_D    = 16'hE308;
    localparam logic [15:0] D_ZERO    = 16'hEA90;
    localparam logic [15:0] D_ONE     = 16'hEFD0;
    localparam logic [15:0] D_INC     = 16'hE7D0;
    localparam logic [15:0] D_JEQ     = 16'hE302;
    localparam logic [15:0] D_JLT     = 16'hE304;
    localparam logic [15:0] D_JGT     = 16'hE301;
    localparam logic [15:0] D_ONLY    = 16'hE300;
    localparam logic [15:0] ZERO_JMP  = 16'hEA87;
    localparam logic [15:0] AMD_MP1   = 16'hFDF8;
    localparam logic [15:0] AM_D_JMP  = 16'hE32F;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;
`ifdef HACK_CPU_HALT_EN
    logic        halted;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mA;
    logic [15:0] mD;
    logic [14:0] mPc;
    logic        mHalt;

    logic [15:0] seenOut;
    logic        seenWrite;
    logic [14:0] seenAddr;

    logic [5:0] compTable [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                   6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                   6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                   6'b000111, 6'b000000, 6'b010101};

    always #5 clk = ~clk;

    hack_cpu #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
`ifdef HACK_CPU_HALT_EN
        ,
        .halted      (halted)
`endif
    );

    // Hack comp mnemonics evaluated directly as arithmetic on D (x) and A/M (y).
    function automatic logic [15:0] refComp(input logic [5:0] c, input logic [15:0] x,
                                            input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one instruction for one cycle, checks the combinational outputs and the
    // architectural pc against the model, then advances the model across the clock edge.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] inm,
                                 input logic rst);
        logic        isC;
        logic [15:0] res;
        logic        jmpTaken;
        logic        expWrite;
        @(negedge clk);
        instruction = instr;
        inM         = inm;
        reset       = rst;
        #1;
        isC      = instr[15];
        res      = refComp(instr[11:6], mD, instr[12] ? inm : mA);
        jmpTaken = isC && ((instr[2] && $signed(res) < 0) ||
                           (instr[1] && res == 16'd0) ||
                           (instr[0] && $signed(res) > 0));
        expWrite = isC && instr[3] && !rst && !mHalt;
        checkOutput("pc", {1'b0, pc}, {1'b0, mPc});
        checkOutput("addressM", {1'b0, addressM}, {1'b0, mA[14:0]});
        checkOutput("writeM", {15'd0, writeM}, {15'd0, expWrite});
        if (isC) checkOutput("outM", outM, res);
`ifdef HACK_CPU_HALT_EN
        checkOutput("halted", {15'd0, halted}, {15'd0, mHalt});
`endif
        seenOut   = outM;
        seenWrite = writeM;
        seenAddr  = addressM;
        @(posedge clk);
        if (rst) begin
            mA    = 16'd0;
            mD    = 16'd0;
            mPc   = RESET_PC;
            mHalt = 1'b0;
        end else if (!mHalt) begin
`ifdef HACK_CPU_HALT_EN
            if (jmpTaken && mA[14:0] == mPc) mHalt = 1'b1;
`endif
            mPc = jmpTaken ? mA[14:0] : mPc + 15'd1;
            if (!isC) mA = instr;
            else begin
                if (instr[5]) mA = res;
                if (instr[4]) mD = res;
            end
        end
        #1;
    endtask

    initial begin
        logic [15:0] rInstr;
        reset       = 1'b1;
        instruction = 16'h0000;
        inM         = 16'h0000;
        mHalt       = 1'b0;
        repeat (2) @(posedge clk);
        mA  = 16'd0;
        mD  = 16'd0;
        mPc = RESET_PC;
        #1;
        checkOutput("reset_pc", {1'b0, pc}, {1'b0, RESET_PC});
        checkOutput("reset_addressM", {1'b0, addressM}, 16'd0);
        checkOutput("reset_writeM", {15'd0, writeM}, 16'd0);

        $display("[TB] add and store");
        applyStimulus(16'd0, 16'd0, 1'b1);
        applyStimulus(16'd2, 16'h1234, 1'b0);
        applyStimulus(D_EQ_A, 16'h1234, 1'b0);
        applyStimulus(16'd3, 16'h1234, 1'b0);
        applyStimulus(D_EQ_DPA, 16'h1234, 1'b0);
        applyStimulus(16'd0, 16'h1234, 1'b0);
        applyStimulus(M_EQ_D, 16'h1234, 1'b0);
        checkOutput("add_outM", seenOut, 16'd5);
        checkOutput("add_writeM", {15'd0, seenWrite}, 16'd1);
        checkOutput("add_addressM", {1'b0, seenAddr}, 16'd0);
        checkOutput("add_pc", {1'b0, pc}, 16'd6);
        applyStimulus(D_ONLY, 16'h0, 1'b0);
        checkOutput("add_D", seenOut, 16'd5);

        $display("[TB] conditional jumps");
        applyStimulus(16'd0, 16'd0, 1'b1);
        applyStimulus(D_ZERO, 16'd0, 1'b0);
        applyStimulus(16'd10, 16'd0, 1'b0);
        applyStimulus(D_JEQ, 16'd0, 1'b0);
        checkOutput("jeq_taken_pc", {1'b0, pc}, 16'd10);
        applyStimulus(D_ONE, 16'd0, 1'b0);
        applyStimulus(16'd10, 16'd0, 1'b0);
        applyStimulus(D_JEQ, 16'd0, 1'b0);
        checkOutput("jeq_not_taken_pc", {1'b0, pc}, 16'd13);
        applyStimulus(16'h7FFF, 16'd0, 1'b0);
        applyStimulus(D_EQ_A, 16'd0, 1'b0);
        applyStimulus(D_INC, 16'd0, 1'b0);
        applyStimulus(16'd10, 16'd0, 1'b0);
        applyStimulus(D_JLT, 16'd0, 1'b0);
        checkOutput("jlt_neg_pc", {1'b0, pc}, 16'd10);
        applyStimulus(D_JGT, 16'd0, 1'b0);
        checkOutput("jgt_neg_pc", {1'b0, pc}, 16'd11);

        $display("[TB] multi-destination");
        applyStimulus(16'd0, 16'd0, 1'b1);
        applyStimulus(16'd7, 16'd0, 1'b0);
        applyStimulus(AMD_MP1, 16'h0041, 1'b0);
        checkOutput("amd_addressM", {1'b0, seenAddr}, 16'd7);
        checkOutput("amd_outM", seenOut, 16'h0042);
        checkOutput("amd_writeM", {15'd0, seenWrite}, 16'd1);
        checkOutput("amd_newA", {1'b0, addressM}, 16'h0042);
        applyStimulus(D_ONLY, 16'd0, 1'b0);
        checkOutput("amd_newD", seenOut, 16'h0042);

        $display("[TB] AM=D;JMP");
        applyStimulus(16'd0, 16'd0, 1'b1);
        applyStimulus(16'd100, 16'd0, 1'b0);
        applyStimulus(D_EQ_A, 16'd0, 1'b0);
        applyStimulus(16'd20, 16'd0, 1'b0);
        applyStimulus(AM_D_JMP, 16'd0, 1'b0);
        checkOutput("amjmp_addressM", {1'b0, seenAddr}, 16'd20);
        checkOutput("amjmp_outM", seenOut, 16'd100);
        checkOutput("amjmp_writeM", {15'd0, seenWrite}, 16'd1);
        checkOutput("amjmp_pc", {1'b0, pc}, 16'd20);
        checkOutput("amjmp_newA", {1'b0, addressM}, 16'd100);

        $display("[TB] pc wrap and mid-program reset");
        applyStimulus(16'h7FFF, 16'd0, 1'b0);
        applyStimulus(ZERO_JMP, 16'd0, 1'b0);
        checkOutput("wrap_top_pc", {1'b0, pc}, 16'h7FFF);
        applyStimulus(16'd5, 16'd0, 1'b0);
        checkOutput("wrap_pc", {1'b0, pc}, 16'd0);
        applyStimulus(D_EQ_A, 16'd0, 1'b0);
        applyStimulus(16'd9, 16'd0, 1'b0);
        applyStimulus(M_EQ_D, 16'd0, 1'b1);
        checkOutput("rst_writeM", {15'd0, seenWrite}, 16'd0);
        checkOutput("rst_pc", {1'b0, pc}, {1'b0, RESET_PC});
        checkOutput("rst_addressM", {1'b0, addressM}, 16'd0);
        applyStimulus(D_ONLY, 16'd0, 1'b0);
        checkOutput("rst_D", seenOut, 16'd0);

`ifdef HACK_CPU_HALT_EN
        $display("[TB] halt");
        applyStimulus(16'd0, 16'd0, 1'b1);
        applyStimulus(16'd4, 16'd0, 1'b0);
        applyStimulus(ZERO_JMP, 16'd0, 1'b0);
        applyStimulus(16'd4, 16'd0, 1'b0);
        applyStimulus(ZERO_JMP, 16'd0, 1'b0);
        checkOutput("halt_not_yet", {15'd0, halted}, 16'd0);
        applyStimulus(16'd6, 16'd0, 1'b0);
        applyStimulus(ZERO_JMP, 16'd0, 1'b0);
        applyStimulus(ZERO_JMP, 16'd0, 1'b0);
        checkOutput("halt_set", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 10; i++) applyStimulus(M_EQ_D, 16'd0, 1'b0);
        checkOutput("halt_pc", {1'b0, pc}, 16'd6);
        applyStimulus(16'd0, 16'd0, 1'b1);
        checkOutput("halt_cleared", {15'd0, halted}, 16'd0);
`endif

        $display("[TB] random instructions");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 40) begin
                rInstr = {1'b0, 15'($urandom)};
            end else begin
                rInstr = {1'b1, 2'($urandom), 1'($urandom),
                          compTable[$urandom_range(17)], 3'($urandom), 3'($urandom)};
            end
            applyStimulus(rInstr, 16'($urandom), $urandom_range(99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
